tagged_block_multiplier: RTL and testbench
==========================================

// Module: tagged_block_multiplier
// PURPOSE
// - Multi-flux (FLUX-channel) tagged dataflow actor for HEVC filter/transform datapaths.
// - Per flux: loads a signed coefficient and a block geometry (h x v), then streams h*v operands.
// - Emits each product scaled, rounded and saturated, tagged with its flux index; returns to IDLE after the block.
// - Sits between per-flux read FIFOs (opA, opB, ext_size, real_size) and a per-flux prod write FIFO.
// PARAMETERS
// FLUX      2                      number of independent data fluxes (>=1)
// A_W       18                     signed operand A data width
// B_W       9                      signed coefficient width
// SIZE_W    7                      block dimension width
// OUT_W     27                     signed result width
// SHIFT     0                      arithmetic right shift applied to product (0..A_W+B_W-1)
// ROUND     1                      1: round-half-up before shift (ignored if SHIFT=0); 0: truncate
// TAG_W     (FLUX>1)?$clog2(FLUX):1  derived, tag width
// PORTS
// clk                  in   1               clock
// rst                  in   1               reset, asynchronous, active-high
// read_port_opA        read_interface.actor   dout TAG_W+A_W, empty/read FLUX; operand stream
// read_port_opB        read_interface.actor   dout TAG_W+B_W, empty/read FLUX; coefficient
// read_port_ext_size   read_interface.actor   dout TAG_W+SIZE_W, empty/read FLUX; rows (max_v)
// read_port_real_size  read_interface.actor   dout TAG_W+SIZE_W, empty/read FLUX; cols (max_h)
// write_port_prod      write_interface.actor  din TAG_W+OUT_W, full/write FLUX; {tag,result}
// BEHAVIOUR
// - Reset (async): all flux states IDLE, cnt_h/cnt_v/coeff/max_h/max_v = 0, rr_ptr=0, out_vld=0;
//   all read[*]=0, write[*]=0, din=0 while rst=1 and in first cycle after.
// - Per-flux state: IDLE, WORK. Eligibility of flux f in a cycle:
//   IDLE: opB, ext_size, real_size all non-empty.
//   WORK: opA non-empty AND full[f]==0 AND NOT (out_vld AND out_tag==f).
// - Arbitration: round-robin over eligible fluxes starting at rr_ptr; winner w; rr_ptr<=w+1 (mod FLUX)
//   on any grant. At most one flux served per cycle; only read[w] bits may assert.
// - IDLE grant: pop opB, ext_size, real_size of w in the same cycle; coeff<=opB, max_h<=real_size,
//   max_v<=ext_size (size 0 loads as 1); cnt_h<=0, cnt_v<=0; state->WORK.
// - WORK grant: pop opA[w]; p = signed(A)*signed(coeff), full A_W+B_W bits;
//   if ROUND and SHIFT>0: p += 1<<(SHIFT-1); r = p>>>SHIFT; saturate r to OUT_W signed range.
//   Registered: out_vld<=1, out_tag<=w, out_dat<=r. Latency pop->write = 1 cycle.
// - Counters: cnt_h<=cnt_h+1; if cnt_h==max_h-1: cnt_h<=0, cnt_v<=cnt_v+1;
//   if additionally cnt_v==max_v-1: cnt_v<=0, state->IDLE (block done; next geometry may load).
// - Output: write[out_tag]=out_vld, din={out_tag,out_dat}; out_vld cleared the cycle after unless
//   a new WORK grant. Write issued unconditionally (full checked at pop time + pending-write guard).
// - Incoming dout tag bits are ignored; data taken from low bits.
// - No grant: no reads, state unchanged; out_vld<=0.
// - Reset mid-block: in-flight product and partial block are discarded; FIFOs untouched.
// STRUCTURE
// - Package mdf_actor_pkg: typedef enum logic {IDLE,WORK} actor_state_t; tag_width() function;
//   sat_shift_round() function (shared with other tagged actors).
// - Sub-module rr_arbiter #(N) : req[N], ptr -> gnt_idx, gnt_vld (pure combinational, reusable).
// - Top: per-flux context arrays, arbiter, combinational next-state, one output register stage.
// TESTING
// - FLUX=2, flux0 coeff=3, h=2,v=2, A={1,2,3,4} -> prod[0]={3,6,9,12}, tag 0, then state IDLE.
// - Both fluxes eligible every cycle -> grants alternate 0,1,0,1; no flux served twice in a row.
// - full[1]=1 while flux1 WORK -> no opA[1] pop, flux0 still served; release full -> resumes, no loss.
// - SHIFT=2,ROUND=1: A=5,coeff=1 -> 1 (5+2>>2); A=-6,coeff=1 -> -1; ROUND=0: A=-6 -> -2.
// - OUT_W=16: A=131071,coeff=255 -> 32767; A=-131072,coeff=255 -> -32768 (saturation).
// - Assert rst during flux0 mid-block (after 1 of 4) -> outputs 0 immediately, next load starts fresh.

Source files
------------

// File: rtl/mdf_actor_pkg.sv
// Shared types and arithmetic helpers for tagged multi-flux dataflow actors.
// Used by tagged_block_multiplier and sibling actors.
package mdf_actor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } actor_state_t;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-half-up (optional), arithmetic shift, then clamp to out_w signed.
  function automatic logic signed [63:0] sat_shift_round(
    input logic signed [63:0] p,
    input int shift,
    input int round,
    input int out_w
  );
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v = p;
    if (round != 0 && shift > 0)
      v = v + (64'sd1 <<< (shift - 1));
    v = v >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi)
      v = hi;
    else if (v < lo)
      v = lo;
    return v;
  endfunction

endpackage

// File: rtl/read_interface.sv
// Multi-flux FIFO read port: one data word, empty and read strobe per flux.
// The actor side pops by asserting read[f] while empty[f] is low.
interface read_interface #(
  parameter int DW = 8,
  parameter int N  = 1
);
  logic [DW-1:0] dout [N];
  logic [N-1:0]  empty;
  logic [N-1:0]  read;

  modport actor (input dout, input empty, output read);
  modport fifo  (output dout, output empty, input read);
endinterface

// File: rtl/write_interface.sv
// Multi-flux FIFO write port: shared data bus, full and write strobe per flux.
// The actor side pushes din into flux f by asserting write[f].
interface write_interface #(
  parameter int DW = 8,
  parameter int N  = 1
);
  logic [DW-1:0] din;
  logic [N-1:0]  full;
  logic [N-1:0]  write;

  modport actor (output din, output write, input full);
  modport fifo  (input din, input write, output full);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Assumes ptr < N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  int idx;

  // Scan from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N)
        idx = idx - N;
      if (req[idx]) begin
        gnt_idx = IW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tagged_block_multiplier.sv
// Multi-flux tagged block multiplier: per flux loads coeff and h x v geometry,
// then streams h*v operands out as scaled, rounded, saturated tagged products.
module tagged_block_multiplier
  import mdf_actor_pkg::*;
#(
  parameter int FLUX   = 2,
  parameter int A_W    = 18,
  parameter int B_W    = 9,
  parameter int SIZE_W = 7,
  parameter int OUT_W  = 27,
  parameter int SHIFT  = 0,
  parameter int ROUND  = 1,
  parameter int TAG_W  = tag_width(FLUX)
) (
  input logic           clk,
  input logic           rst,
  read_interface.actor  read_port_opA,
  read_interface.actor  read_port_opB,
  read_interface.actor  read_port_ext_size,
  read_interface.actor  read_port_real_size,
  write_interface.actor write_port_prod
);

  localparam int P_W = A_W + B_W;
  localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

  actor_state_t          state [FLUX];
  logic signed [B_W-1:0] coeff [FLUX];
  logic [SIZE_W-1:0]     max_h [FLUX];
  logic [SIZE_W-1:0]     max_v [FLUX];
  logic [SIZE_W-1:0]     cnt_h [FLUX];
  logic [SIZE_W-1:0]     cnt_v [FLUX];

  logic [TAG_W-1:0]        rr_ptr;
  logic [TAG_W-1:0]        gnt_idx;
  logic [TAG_W-1:0]        out_tag;
  logic                    gnt_vld;
  logic                    out_vld;
  logic                    boot;
  logic signed [OUT_W-1:0] out_dat;
  logic [FLUX-1:0]         req;
  logic                    gnt_idle;
  logic                    gnt_work;

  logic signed [A_W-1:0] a_cur;
  logic signed [B_W-1:0] c_cur;
  logic signed [P_W-1:0] prod;
  logic signed [63:0]    p_ext;
  logic signed [63:0]    r_ext;
  logic [SIZE_W-1:0]     ld_h;
  logic [SIZE_W-1:0]     ld_v;
  logic                  unused_bits;

  // boot holds off grants in the first cycle after reset release.
  always_comb begin
    req = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (state[f] == IDLE)
        req[f] = !read_port_opB.empty[f]
               && !read_port_ext_size.empty[f]
               && !read_port_real_size.empty[f];
      else
        req[f] = !read_port_opA.empty[f]
               && !write_port_prod.full[f]
               && !(out_vld && out_tag == TAG_W'(f));
    end
    if (boot)
      req = '0;
  end

  rr_arbiter #(
    .N  (FLUX),
    .IW (TAG_W)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign gnt_idle = gnt_vld && (state[gnt_idx] == IDLE);
  assign gnt_work = gnt_vld && (state[gnt_idx] == WORK);

  always_comb begin
    read_port_opA.read       = '0;
    read_port_opB.read       = '0;
    read_port_ext_size.read  = '0;
    read_port_real_size.read = '0;
    if (gnt_idle) begin
      read_port_opB.read[gnt_idx]       = 1'b1;
      read_port_ext_size.read[gnt_idx]  = 1'b1;
      read_port_real_size.read[gnt_idx] = 1'b1;
    end
    if (gnt_work)
      read_port_opA.read[gnt_idx] = 1'b1;
  end

  always_comb begin
    a_cur = read_port_opA.dout[gnt_idx][A_W-1:0];
    c_cur = coeff[gnt_idx];
    prod  = a_cur * c_cur;
    p_ext = {{(64 - P_W){prod[P_W-1]}}, prod};
    r_ext = sat_shift_round(p_ext, SHIFT, ROUND, OUT_W);
    ld_h  = read_port_real_size.dout[gnt_idx][SIZE_W-1:0];
    ld_v  = read_port_ext_size.dout[gnt_idx][SIZE_W-1:0];
    if (ld_h == '0)
      ld_h = ONE;
    if (ld_v == '0)
      ld_v = ONE;
  end

  // Tag bits on incoming words carry no information for this actor.
  always_comb begin
    unused_bits = ^r_ext[63:OUT_W];
    for (int f = 0; f < FLUX; f++) begin
      unused_bits = unused_bits
                  ^ (^read_port_opA.dout[f][TAG_W+A_W-1:A_W])
                  ^ (^read_port_opB.dout[f][TAG_W+B_W-1:B_W])
                  ^ (^read_port_ext_size.dout[f][TAG_W+SIZE_W-1:SIZE_W])
                  ^ (^read_port_real_size.dout[f][TAG_W+SIZE_W-1:SIZE_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        state[f] <= IDLE;
        coeff[f] <= '0;
        max_h[f] <= '0;
        max_v[f] <= '0;
        cnt_h[f] <= '0;
        cnt_v[f] <= '0;
      end
      rr_ptr  <= '0;
      out_vld <= 1'b0;
      out_tag <= '0;
      out_dat <= '0;
      boot    <= 1'b1;
    end else begin
      boot    <= 1'b0;
      out_vld <= gnt_work;
      if (gnt_vld)
        rr_ptr <= (gnt_idx == TAG_W'(FLUX - 1)) ? '0 : gnt_idx + TAG_W'(1);
      if (gnt_idle) begin
        state[gnt_idx] <= WORK;
        coeff[gnt_idx] <= read_port_opB.dout[gnt_idx][B_W-1:0];
        max_h[gnt_idx] <= ld_h;
        max_v[gnt_idx] <= ld_v;
        cnt_h[gnt_idx] <= '0;
        cnt_v[gnt_idx] <= '0;
      end
      if (gnt_work) begin
        out_tag <= gnt_idx;
        out_dat <= r_ext[OUT_W-1:0];
        if (cnt_h[gnt_idx] == max_h[gnt_idx] - ONE) begin
          cnt_h[gnt_idx] <= '0;
          if (cnt_v[gnt_idx] == max_v[gnt_idx] - ONE) begin
            cnt_v[gnt_idx] <= '0;
            state[gnt_idx] <= IDLE;
          end else begin
            cnt_v[gnt_idx] <= cnt_v[gnt_idx] + ONE;
          end
        end else begin
          cnt_h[gnt_idx] <= cnt_h[gnt_idx] + ONE;
        end
      end
    end
  end

  always_comb begin
    write_port_prod.write = '0;
    if (out_vld)
      write_port_prod.write[out_tag] = 1'b1;
    write_port_prod.din = {out_tag, out_dat};
  end

endmodule

// File: tb/tb_tagged_block_multiplier.sv
// Scoreboard bench for tagged_block_multiplier: queue-modelled FIFOs,
// per-flux expected-product queues and a monitor on the prod write port.
module tb_tagged_block_multiplier;

  localparam int FLUX   = 2;
  localparam int A_W    = 18;
  localparam int B_W    = 9;
  localparam int SIZE_W = 7;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 2;
  localparam int ROUND  = 1;
  localparam int TAG_W  = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  read_interface  #(.DW(TAG_W + A_W),    .N(FLUX)) opa_if ();
  read_interface  #(.DW(TAG_W + B_W),    .N(FLUX)) opb_if ();
  read_interface  #(.DW(TAG_W + SIZE_W), .N(FLUX)) ext_if ();
  read_interface  #(.DW(TAG_W + SIZE_W), .N(FLUX)) real_if ();
  write_interface #(.DW(TAG_W + OUT_W),  .N(FLUX)) prod_if ();

  tagged_block_multiplier #(
    .FLUX   (FLUX),
    .A_W    (A_W),
    .B_W    (B_W),
    .SIZE_W (SIZE_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT),
    .ROUND  (ROUND)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .read_port_opA       (opa_if),
    .read_port_opB       (opb_if),
    .read_port_ext_size  (ext_if),
    .read_port_real_size (real_if),
    .write_port_prod     (prod_if)
  );

  always #5 clk = ~clk;

  int qa [FLUX][$];
  int qb [FLUX][$];
  int qe [FLUX][$];
  int qr [FLUX][$];
  int exp_q [FLUX][$];
  int wr_log [$];
  int wr_cnt [FLUX];

  logic [FLUX-1:0] rd_a, rd_b, rd_e, rd_r;
  logic [FLUX-1:0] full_req;

  int checks = 0;
  int errors = 0;

  // Reference: floor((a*c + half) / 2^SHIFT), clamped to OUT_W signed.
  function automatic int model(input int a, input int c);
    longint p, d, q, hi, lo;
    p = longint'(a) * longint'(c);
    d = longint'(1) << SHIFT;
    if (ROUND != 0 && SHIFT > 0)
      p = p + d / 2;
    q = p / d;
    if ((p % d) != 0 && p < 0)
      q = q - 1;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return int'(q);
  endfunction

  task automatic add_geo(input int f, input int c, input int h, input int v);
    qb[f].push_back(c);
    qr[f].push_back(h);
    qe[f].push_back(v);
  endtask

  task automatic add_a(input int f, input int a, input int e);
    qa[f].push_back(a);
    exp_q[f].push_back(e);
  endtask

  task automatic add_rand_block(input int f);
    int c, h, v, n, a;
    c = int'($urandom_range(0, 511)) - 256;
    h = int'($urandom_range(0, 3));
    v = int'($urandom_range(0, 3));
    n = (h == 0 ? 1 : h) * (v == 0 ? 1 : v);
    add_geo(f, c, h, v);
    for (int i = 0; i < n; i++) begin
      a = int'($urandom_range(0, 262143)) - 131072;
      add_a(f, a, model(a, c));
    end
  endtask

  // FIFO side: commit pops seen in the cycle, then present new heads.
  always @(posedge clk) begin
    #1;
    for (int f = 0; f < FLUX; f++) begin
      if (rd_a[f] || rd_b[f] || rd_e[f] || rd_r[f]) begin
        checks++;
        if ((rd_a[f] && qa[f].size() == 0) || (rd_b[f] && qb[f].size() == 0)
            || (rd_e[f] && qe[f].size() == 0) || (rd_r[f] && qr[f].size() == 0)) begin
          errors++;
          $display("FAIL pop_empty flux %0d: read a/b/e/r=%b%b%b%b on empty queue",
                   f, rd_a[f], rd_b[f], rd_e[f], rd_r[f]);
        end
      end
      if (rd_a[f] && qa[f].size() != 0) void'(qa[f].pop_front());
      if (rd_b[f] && qb[f].size() != 0) void'(qb[f].pop_front());
      if (rd_e[f] && qe[f].size() != 0) void'(qe[f].pop_front());
      if (rd_r[f] && qr[f].size() != 0) void'(qr[f].pop_front());
      opa_if.empty[f]  = (qa[f].size() == 0);
      opb_if.empty[f]  = (qb[f].size() == 0);
      ext_if.empty[f]  = (qe[f].size() == 0);
      real_if.empty[f] = (qr[f].size() == 0);
      opa_if.dout[f]  = {1'($urandom), (qa[f].size() != 0) ? 18'(qa[f][0]) : 18'($urandom)};
      opb_if.dout[f]  = {1'($urandom), (qb[f].size() != 0) ? 9'(qb[f][0]) : 9'($urandom)};
      ext_if.dout[f]  = {1'($urandom), (qe[f].size() != 0) ? 7'(qe[f][0]) : 7'($urandom)};
      real_if.dout[f] = {1'($urandom), (qr[f].size() != 0) ? 7'(qr[f][0]) : 7'($urandom)};
    end
    prod_if.full = full_req;
  end

  // Monitor: sample strobes mid-cycle and score every write.
  always @(negedge clk) begin
    int e, got;
    rd_a = opa_if.read;
    rd_b = opb_if.read;
    rd_e = ext_if.read;
    rd_r = real_if.read;
    if (!rst) begin
      if (prod_if.write != '0) begin
        checks++;
        if ($countones(prod_if.write) != 1) begin
          errors++;
          $display("FAIL write_onehot: write=%b required one-hot", prod_if.write);
        end
      end
      for (int f = 0; f < FLUX; f++) begin
        if (opa_if.read[f]) begin
          checks++;
          if (prod_if.full[f]) begin
            errors++;
            $display("FAIL pop_while_full flux %0d: opA read with full=1", f);
          end
        end
        if (prod_if.write[f]) begin
          wr_log.push_back(f);
          wr_cnt[f]++;
          checks++;
          got = int'($signed(prod_if.din[OUT_W-1:0]));
          if (exp_q[f].size() == 0) begin
            errors++;
            $display("FAIL unexpected_write flux %0d: got %0d, none expected", f, got);
          end else begin
            e = exp_q[f].pop_front();
            if (got != e || prod_if.din[OUT_W] != 1'(f)) begin
              errors++;
              $display("FAIL prod flux %0d: got tag %0d data %0d, required tag %0d data %0d",
                       f, prod_if.din[OUT_W], got, f, e);
            end
          end
        end
      end
    end
  end

  task automatic wait_drain(input int budget, input string nm);
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if ((exp_q[0].size() + exp_q[1].size() + qa[0].size() + qa[1].size()) != 0) begin
      errors++;
      $display("FAIL %s: %0d products and %0d operands outstanding, required 0",
               nm, exp_q[0].size() + exp_q[1].size(), qa[0].size() + qa[1].size());
    end
  endtask

  task automatic check_quiet(input string nm);
    checks++;
    if (prod_if.write != '0 || prod_if.din != '0 || opa_if.read != '0
        || opb_if.read != '0 || ext_if.read != '0 || real_if.read != '0) begin
      errors++;
      $display("FAIL %s: write=%b din=%h reads=%b%b%b%b, required all 0", nm,
               prod_if.write, prod_if.din, opa_if.read, opb_if.read, ext_if.read, real_if.read);
    end
  endtask

  initial begin
    int c0, c1, n;
    full_req = '0;
    rd_a = '0; rd_b = '0; rd_e = '0; rd_r = '0;
    wr_cnt[0] = 0;
    wr_cnt[1] = 0;
    #1 rst = 1'b1;
    #1 check_quiet("reset_async");
    repeat (3) @(negedge clk);
    check_quiet("reset_held");
    rst = 1'b0;
    #1 check_quiet("reset_release");

    // Basic block: coeff 3, 2x2
    @(negedge clk);
    add_geo(0, 3, 2, 2);
    add_a(0, 1, 1); add_a(0, 2, 2); add_a(0, 3, 2); add_a(0, 4, 3);
    wait_drain(100, "basic_block");

    // Rounding and degenerate geometry
    add_geo(1, 1, 1, 2);
    add_a(1, 5, 1); add_a(1, -6, -1);
    add_geo(1, -2, 0, 0);
    add_a(1, 7, -3);
    wait_drain(100, "rounding");

    // Saturation
    add_geo(0, 255, 1, 2);
    add_a(0, 131071, 32767); add_a(0, -131072, -32768);
    wait_drain(100, "saturation");

    // Both fluxes busy: writes must alternate
    wr_log.delete();
    add_geo(0, 5, 4, 2);
    add_geo(1, -7, 4, 2);
    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(0, 262143)) - 131072;
      add_a(0, n, model(n, 5));
      n = int'($urandom_range(0, 262143)) - 131072;
      add_a(1, n, model(n, -7));
    end
    wait_drain(200, "alternate");
    checks++;
    if (wr_log.size() != 16) begin
      errors++;
      $display("FAIL alternate_count: got %0d writes, required 16", wr_log.size());
    end
    for (int i = 1; i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i] == wr_log[i-1]) begin
        errors++;
        $display("FAIL alternate %0d: tag %0d repeated", i, wr_log[i]);
      end
    end

    // Backpressure on flux 1
    full_req = 2'b10;
    @(negedge clk);
    @(negedge clk);
    c0 = wr_cnt[0];
    c1 = wr_cnt[1];
    add_geo(0, 9, 3, 2);
    add_geo(1, 11, 3, 2);
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(0, 262143)) - 131072;
      add_a(0, n, model(n, 9));
      n = int'($urandom_range(0, 262143)) - 131072;
      add_a(1, n, model(n, 11));
    end
    repeat (30) @(negedge clk);
    checks++;
    if (wr_cnt[1] != c1 || wr_cnt[0] - c0 != 6) begin
      errors++;
      $display("FAIL backpressure: flux0 wrote %0d flux1 wrote %0d, required 6 and 0",
               wr_cnt[0] - c0, wr_cnt[1] - c1);
    end
    full_req = '0;
    wait_drain(200, "backpressure_release");

    // Randomized traffic with random full
    n = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0 && n < 30) begin
        add_rand_block(int'($urandom_range(0, 1)));
        n++;
      end
      full_req[0] = ($urandom_range(0, 3) == 0);
      full_req[1] = ($urandom_range(0, 3) == 0);
    end
    full_req = '0;
    wait_drain(2000, "random");

    // Reset after the first of four operands
    add_geo(0, 1, 2, 2);
    add_a(0, 8, 2);
    wait_drain(100, "pre_reset");
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_quiet("reset_mid_block");
    @(negedge clk);
    add_geo(0, 2, 1, 1);
    add_a(0, 8, 4);
    repeat (2) @(negedge clk);
    check_quiet("reset_mid_held");
    rst = 1'b0;
    #1 check_quiet("reset_first_cycle");
    wait_drain(100, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
